prog_loader: RTL

// Writer side of the program-memory port: streams a byte image from outside the chip into mem

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/ldr_checksum.sv | 28 ++
 rtl/prog_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared widths, loader FSM state codes and the busy-state decode.
// Imported by the loader top and its checksum accumulator.
package prog_loader_pkg;

    localparam int LDR_ADDR_W = 16;
    localparam int LDR_DATA_W = 8;

    localparam logic [2:0] LDR_IDLE    = 3'd0;
    localparam logic [2:0] LDR_WRITE   = 3'd1;
    localparam logic [2:0] LDR_VERIFY  = 3'd2;
    localparam logic [2:0] LDR_RELEASE = 3'd3;
    localparam logic [2:0] LDR_DONE    = 3'd4;
    localparam logic [2:0] LDR_ERROR   = 3'd5;

    function automatic logic ldr_is_busy(input logic [2:0] st);
        return (st == LDR_WRITE) || (st == LDR_VERIFY) || (st == LDR_RELEASE);
    endfunction

endpackage

// File: rtl/ldr_checksum.sv
// Running modulo-2^DATA_WIDTH byte sum; o_sum already includes this cycle's add.
// Zero latency on o_sum, no backpressure; clear wins over add.
module ldr_checksum
    import prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH = LDR_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_add_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_sum
);

    logic [DATA_WIDTH-1:0] r_sum;

    assign o_sum = i_add_en ? (r_sum + i_data) : r_sum;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_sum <= '0;
        end else begin
            r_sum <= o_sum;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a byte image into program memory with the core held in reset, verifies it by read-back
// checksum, then releases the core and pulses get_next; stream accepted one byte/cycle in WRITE only.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = LDR_ADDR_W,
    parameter int DATA_WIDTH = LDR_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_length,
    input  logic                  i_s_valid,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_s_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_din,
    input  logic [DATA_WIDTH-1:0] i_mem_dout,
    output logic                  o_manual_mem,
    output logic                  o_core_rst_n,
    output logic                  o_trigger,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_trigger;

    logic                  w_start_acc;
    logic                  w_xfer;
    logic                  w_in_write;
    logic                  w_in_verify;
    logic                  w_verify_last;
    logic                  w_rsum_add;
    logic                  w_owned;
    logic [DATA_WIDTH-1:0] w_wsum;
    logic [DATA_WIDTH-1:0] w_rsum;

    assign w_in_write    = (r_state == LDR_WRITE);
    assign w_in_verify   = (r_state == LDR_VERIFY);
    assign w_start_acc   = i_start && ((r_state == LDR_IDLE) || (r_state == LDR_DONE) ||
                                       (r_state == LDR_ERROR));
    assign w_xfer        = w_in_write && i_s_valid;
    assign w_verify_last = w_in_verify && (r_cnt == r_len);
    // Read data lags the address by one cycle, so the first VERIFY cycle has nothing to add.
    assign w_rsum_add    = w_in_verify && (r_cnt != '0);

    ldr_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_wsum (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_start_acc),
        .i_add_en (w_xfer),
        .i_data   (i_s_data),
        .o_sum    (w_wsum)
    );

    ldr_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_rsum (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_start_acc),
        .i_add_en (w_rsum_add),
        .i_data   (i_mem_dout),
        .o_sum    (w_rsum)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= LDR_IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_trigger <= 1'b0;
        end else begin
            r_trigger <= (r_state == LDR_RELEASE);
            case (r_state)
                LDR_IDLE, LDR_DONE, LDR_ERROR: begin
                    if (w_start_acc) begin
                        r_base  <= i_base_addr;
                        r_len   <= i_length;
                        r_cnt   <= '0;
                        r_state <= (i_length == '0) ? LDR_VERIFY : LDR_WRITE;
                    end
                end
                LDR_WRITE: begin
                    if (w_xfer) begin
                        if (r_cnt == (r_len - ONE_A)) begin
                            r_cnt   <= '0;
                            r_state <= LDR_VERIFY;
                        end else begin
                            r_cnt <= r_cnt + ONE_A;
                        end
                    end
                end
                LDR_VERIFY: begin
                    if (w_verify_last) begin
                        r_cnt   <= '0;
                        r_state <= (w_rsum == w_wsum) ? LDR_RELEASE : LDR_ERROR;
                    end else begin
                        r_cnt <= r_cnt + ONE_A;
                    end
                end
                LDR_RELEASE: r_state <= LDR_DONE;
                default:     r_state <= LDR_IDLE;
            endcase
        end
    end

    // A start in DONE grabs the mem port and re-holds the core in the same cycle.
    assign w_owned = !((r_state == LDR_RELEASE) || (r_state == LDR_DONE)) ||
                     ((r_state == LDR_DONE) && i_start);

    assign o_s_ready    = w_in_write;
    assign o_mem_we     = w_xfer;
    assign o_mem_addr   = (w_in_write || w_in_verify) ? (r_base + r_cnt) : '0;
    assign o_mem_din    = w_xfer ? i_s_data : '0;
    assign o_manual_mem = w_owned;
    assign o_core_rst_n = !w_owned;
    assign o_trigger    = r_trigger;
    assign o_busy       = ldr_is_busy(r_state);
    assign o_done       = (r_state == LDR_DONE);
    assign o_error      = (r_state == LDR_ERROR);

endmodule
